// File: rtl/ysyx_22051013_id_scoreboard_if.sv
// Issue-stage bundle: the decoded instruction presented by ID and the EX issue
// register it is loaded into. master = surrounding pipeline, slave = scoreboard.
interface ysyx_22051013_id_scoreboard_if #(
  parameter int XLEN = 64
);
  logic            id_valid;
  logic            id_ready;
  logic            rs1_ena;
  logic            rs2_ena;
  logic [4:0]      rs1_addr;
  logic [4:0]      rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            rd_ena;
  logic [4:0]      rd_addr;
  logic            rd_long;
  logic            ex_ready;
  logic            ex_valid;
  logic [XLEN-1:0] ex_op1;
  logic [XLEN-1:0] ex_op2;
  logic            ex_rd_ena;
  logic [4:0]      ex_rd_addr;
  logic            ex_rd_long;

  modport master (
    output id_valid, rs1_ena, rs2_ena, rs1_addr, rs2_addr, rs1_data, rs2_data,
           rd_ena, rd_addr, rd_long, ex_ready,
    input  id_ready, ex_valid, ex_op1, ex_op2, ex_rd_ena, ex_rd_addr, ex_rd_long
  );

  modport slave (
    input  id_valid, rs1_ena, rs2_ena, rs1_addr, rs2_addr, rs1_data, rs2_data,
           rd_ena, rd_addr, rd_long, ex_ready,
    output id_ready, ex_valid, ex_op1, ex_op2, ex_rd_ena, ex_rd_addr, ex_rd_long
  );
endinterface

// File: rtl/ysyx_22051013_id_scoreboard.sv
// ID-stage scoreboard: tracks outstanding long-latency writes, detects RAW/WAW/
// capacity hazards, resolves operands through forwarding and drives the EX register.
module ysyx_22051013_id_scoreboard #(
  parameter int XLEN       = 64,
  parameter int FWD_STAGES = 3,
  parameter int MAX_LONG   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_22051013_id_scoreboard_if.slave  sb,
  input  logic [FWD_STAGES-1:0]         fwd_vld,
  input  logic [5*FWD_STAGES-1:0]       fwd_addr,
  input  logic [XLEN*FWD_STAGES-1:0]    fwd_data,
  input  logic                          wb_valid,
  input  logic [4:0]                    wb_addr,
  input  logic [XLEN-1:0]               wb_data,
  input  logic                          flush,
  output logic [$clog2(MAX_LONG+1)-1:0] pend_cnt
);
  localparam int            CW       = $clog2(MAX_LONG + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(MAX_LONG);

  // Lowest-index forward stage wins, then the completing long write, then the regfile.
  function automatic logic [XLEN-1:0] resolve_op(
    input logic                         ena,
    input logic [4:0]                   addr,
    input logic [XLEN-1:0]              rf_data,
    input logic [FWD_STAGES-1:0]        vld,
    input logic [5*FWD_STAGES-1:0]      faddr,
    input logic [XLEN*FWD_STAGES-1:0]   fdata,
    input logic                         wbv,
    input logic [4:0]                   wba,
    input logic [XLEN-1:0]              wbd
  );
    logic [XLEN-1:0] res;
    logic            hit;
    res = rf_data;
    hit = 1'b0;
    if (!ena || (addr == 5'd0)) begin
      res = {XLEN{1'b0}};
    end else begin
      for (int i = 0; i < FWD_STAGES; i++) begin
        if (!hit && vld[i] && (faddr[5*i +: 5] == addr)) begin
          res = fdata[XLEN*i +: XLEN];
          hit = 1'b1;
        end else begin
          hit = hit;
        end
      end
      if (!hit && wbv && (wba == addr)) begin
        res = wbd;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  logic [31:0]     pend_r;
  logic [CW-1:0]   pend_cnt_r;
  logic            ex_valid_r;
  logic [XLEN-1:0] ex_op1_r;
  logic [XLEN-1:0] ex_op2_r;
  logic            ex_rd_ena_r;
  logic [4:0]      ex_rd_addr_r;
  logic            ex_rd_long_r;

  logic            wb_rs1_s;
  logic            wb_rs2_s;
  logic            wb_rd_s;
  logic            haz_rs1_s;
  logic            haz_rs2_s;
  logic            haz_waw_s;
  logic            haz_cap_s;
  logic            rd_long_s;
  logic            slot_free_s;
  logic            id_ready_s;
  logic            issue_long_s;
  logic [XLEN-1:0] op1_s;
  logic [XLEN-1:0] op2_s;
  logic            wb_clr_s;
  logic            fl_clr_s;
  logic            dec_two_s;
  logic [31:0]     set_mask_s;
  logic [31:0]     clr_mask_s;
  logic [31:0]     pend_nxt_s;
  logic [CW-1:0]   cnt_nxt_s;

  // A completing write in this very cycle releases the hazard on its index.
  assign wb_rs1_s  = wb_valid & (wb_addr == sb.rs1_addr);
  assign wb_rs2_s  = wb_valid & (wb_addr == sb.rs2_addr);
  assign wb_rd_s   = wb_valid & (wb_addr == sb.rd_addr);

  assign haz_rs1_s = sb.rs1_ena & (sb.rs1_addr != 5'd0) & pend_r[sb.rs1_addr] & ~wb_rs1_s;
  assign haz_rs2_s = sb.rs2_ena & (sb.rs2_addr != 5'd0) & pend_r[sb.rs2_addr] & ~wb_rs2_s;
  assign haz_waw_s = sb.rd_ena  & (sb.rd_addr  != 5'd0) & pend_r[sb.rd_addr]  & ~wb_rd_s;
  assign rd_long_s = sb.rd_long & sb.rd_ena & (sb.rd_addr != 5'd0);
  assign haz_cap_s = rd_long_s & (pend_cnt_r == CNT_FULL) & ~wb_valid;

  assign slot_free_s  = ~ex_valid_r | sb.ex_ready;
  assign id_ready_s   = sb.id_valid & ~flush & slot_free_s
                      & ~(haz_rs1_s | haz_rs2_s | haz_waw_s | haz_cap_s);
  assign issue_long_s = id_ready_s & rd_long_s;

  assign op1_s = resolve_op(sb.rs1_ena, sb.rs1_addr, sb.rs1_data, fwd_vld, fwd_addr,
                            fwd_data, wb_valid, wb_addr, wb_data);
  assign op2_s = resolve_op(sb.rs2_ena, sb.rs2_addr, sb.rs2_data, fwd_vld, fwd_addr,
                            fwd_data, wb_valid, wb_addr, wb_data);

  // Only indices that are actually pending are released, so the counter never underflows.
  assign wb_clr_s   = wb_valid & pend_r[wb_addr];
  assign fl_clr_s   = flush & ex_valid_r & ex_rd_long_r & ex_rd_ena_r & pend_r[ex_rd_addr_r];
  assign dec_two_s  = wb_clr_s & fl_clr_s & (wb_addr != ex_rd_addr_r);
  assign set_mask_s = issue_long_s ? (32'd1 << sb.rd_addr) : 32'd0;
  assign clr_mask_s = (wb_clr_s ? (32'd1 << wb_addr) : 32'd0)
                    | (fl_clr_s ? (32'd1 << ex_rd_addr_r) : 32'd0);
  assign pend_nxt_s = ((pend_r & ~clr_mask_s) | set_mask_s) & 32'hFFFF_FFFE;
  assign cnt_nxt_s  = pend_cnt_r + CW'(issue_long_s) - CW'(wb_clr_s | fl_clr_s) - CW'(dec_two_s);

  // Pending bitmap and outstanding-write counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_r     <= 32'd0;
      pend_cnt_r <= {CW{1'b0}};
    end else begin
      pend_r     <= pend_nxt_s;
      pend_cnt_r <= cnt_nxt_s;
    end
  end

  // EX issue register: flush kills, issue loads, consumption without refill empties.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_r   <= 1'b0;
      ex_op1_r     <= {XLEN{1'b0}};
      ex_op2_r     <= {XLEN{1'b0}};
      ex_rd_ena_r  <= 1'b0;
      ex_rd_addr_r <= 5'd0;
      ex_rd_long_r <= 1'b0;
    end else if (flush) begin
      ex_valid_r   <= 1'b0;
    end else if (id_ready_s) begin
      ex_valid_r   <= 1'b1;
      ex_op1_r     <= op1_s;
      ex_op2_r     <= op2_s;
      ex_rd_ena_r  <= sb.rd_ena;
      ex_rd_addr_r <= sb.rd_addr;
      ex_rd_long_r <= sb.rd_long;
    end else if (sb.ex_ready) begin
      ex_valid_r   <= 1'b0;
    end else begin
      ex_valid_r   <= ex_valid_r;
    end
  end

  assign sb.id_ready   = id_ready_s;
  assign sb.ex_valid   = ex_valid_r;
  assign sb.ex_op1     = ex_op1_r;
  assign sb.ex_op2     = ex_op2_r;
  assign sb.ex_rd_ena  = ex_rd_ena_r;
  assign sb.ex_rd_addr = ex_rd_addr_r;
  assign sb.ex_rd_long = ex_rd_long_r;
  assign pend_cnt      = pend_cnt_r;
endmodule

// File: tb/tb_ysyx_22051013_id_scoreboard.sv
// Bench for the ID scoreboard: directed scenarios plus a randomized run checked
// against a register-set model (pending set, EX slot) built from the issue rules.
module tb_ysyx_22051013_id_scoreboard;
  localparam int XLEN = 64;
  localparam int MAXL = 4;

  logic         clk;
  logic         rst;
  logic [2:0]   fwd_vld;
  logic [14:0]  fwd_addr;
  logic [191:0] fwd_data;
  logic         wb_valid;
  logic [4:0]   wb_addr;
  logic [63:0]  wb_data;
  logic         flush;
  logic [2:0]   pend_cnt;
  int           total;
  int           bad;

  ysyx_22051013_id_scoreboard_if #(.XLEN(XLEN)) sb ();

  ysyx_22051013_id_scoreboard #(.XLEN(XLEN), .FWD_STAGES(3), .MAX_LONG(MAXL)) dut (
    .clk(clk), .rst(rst), .sb(sb), .fwd_vld(fwd_vld), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .pend_cnt(pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state
  bit [31:0]   pend_m;
  bit          ex_v_m;
  logic [63:0] op1_m, op2_m;
  bit          rde_m, rdl_m;
  logic [4:0]  rda_m;

  task automatic idle();
    sb.id_valid = 1'b0; sb.rs1_ena = 1'b0; sb.rs2_ena = 1'b0;
    sb.rs1_addr = 5'd0; sb.rs2_addr = 5'd0; sb.rs1_data = 64'd0; sb.rs2_data = 64'd0;
    sb.rd_ena = 1'b0; sb.rd_addr = 5'd0; sb.rd_long = 1'b0; sb.ex_ready = 1'b1;
    fwd_vld = 3'd0; fwd_addr = 15'd0; fwd_data = 192'd0;
    wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 64'd0; flush = 1'b0;
  endtask

  task automatic instr(input logic r1e, input logic [4:0] r1a, input logic [63:0] r1d,
                       input logic r2e, input logic [4:0] r2a, input logic [63:0] r2d,
                       input logic rde, input logic [4:0] rda, input logic rdl);
    sb.id_valid = 1'b1;
    sb.rs1_ena = r1e; sb.rs1_addr = r1a; sb.rs1_data = r1d;
    sb.rs2_ena = r2e; sb.rs2_addr = r2a; sb.rs2_data = r2d;
    sb.rd_ena = rde; sb.rd_addr = rda; sb.rd_long = rdl;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [63:0] m_operand(input bit ena, input logic [4:0] a, input logic [63:0] rfd);
    if (!ena || a == 5'd0) return 64'd0;
    for (int s = 0; s < 3; s++)
      if (fwd_vld[s] && fwd_addr[5*s +: 5] == a) return fwd_data[64*s +: 64];
    if (wb_valid && wb_addr == a) return wb_data;
    return rfd;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    idle();
    @(posedge clk); #1;
    total++; if (sb.ex_valid !== 1'b0) begin bad++; $display("FAIL reset_ex_valid: got %0b want 0", sb.ex_valid); end
    total++; if ({sb.ex_op1, sb.ex_op2} !== 128'd0) begin bad++; $display("FAIL reset_ops: got %h %h want 0", sb.ex_op1, sb.ex_op2); end
    total++; if ({sb.ex_rd_ena, sb.ex_rd_addr, sb.ex_rd_long} !== 7'd0) begin bad++; $display("FAIL reset_rd: got %b want 0", {sb.ex_rd_ena, sb.ex_rd_addr, sb.ex_rd_long}); end
    total++; if (pend_cnt !== 3'd0) begin bad++; $display("FAIL reset_pend_cnt: got %0d want 0", pend_cnt); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_load_use();
    @(negedge clk); idle(); instr(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 1'b1); #1;
    total++; if (sb.id_ready !== 1'b1) begin bad++; $display("FAIL load_issue: id_ready=%0b want 1", sb.id_ready); end
    @(posedge clk); #1;
    total++; if ({sb.ex_valid, sb.ex_rd_ena, sb.ex_rd_addr, sb.ex_rd_long} !== {1'b1, 1'b1, 5'd5, 1'b1}) begin bad++; $display("FAIL load_ex: got %b", {sb.ex_valid, sb.ex_rd_ena, sb.ex_rd_addr, sb.ex_rd_long}); end
    total++; if (pend_cnt !== 3'd1) begin bad++; $display("FAIL load_pend_cnt: got %0d want 1", pend_cnt); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); idle(); instr(1'b1, 5'd5, 64'h1111, 1'b0, 5'd0, 64'd0, 1'b1, 5'd6, 1'b0); #1;
      total++; if (sb.id_ready !== 1'b0) begin bad++; $display("FAIL use_stall: cycle %0d id_ready=%0b want 0", c, sb.id_ready); end
      @(posedge clk); #1;
      total++; if (sb.ex_valid !== 1'b0) begin bad++; $display("FAIL use_bubble: ex_valid=%0b want 0", sb.ex_valid); end
    end
    @(negedge clk); wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 64'h55; #1;
    total++; if (sb.id_ready !== 1'b1) begin bad++; $display("FAIL use_wb_release: id_ready=%0b want 1", sb.id_ready); end
    @(posedge clk); #1;
    total++; if (sb.ex_op1 !== 64'h55) begin bad++; $display("FAIL use_wb_bypass: ex_op1=%h want 55", sb.ex_op1); end
    total++; if (pend_cnt !== 3'd0) begin bad++; $display("FAIL use_pend_clear: got %0d want 0", pend_cnt); end
    @(negedge clk); idle();
  endtask

  task automatic test_fwd_priority();
    @(negedge clk); idle();
    fwd_vld = 3'b011; fwd_addr = {5'd7, 5'd7, 5'd7}; fwd_data = {64'hC, 64'hB, 64'hA};
    instr(1'b1, 5'd7, 64'h77, 1'b0, 5'd7, 64'h99, 1'b1, 5'd10, 1'b0); #1;
    total++; if (sb.id_ready !== 1'b1) begin bad++; $display("FAIL fwd_issue: id_ready=%0b want 1", sb.id_ready); end
    @(posedge clk); #1;
    total++; if (sb.ex_op1 !== 64'hA) begin bad++; $display("FAIL fwd_stage0: ex_op1=%h want a", sb.ex_op1); end
    total++; if (sb.ex_op2 !== 64'h0) begin bad++; $display("FAIL fwd_disabled_rs2: ex_op2=%h want 0", sb.ex_op2); end
    @(negedge clk); fwd_vld = 3'b100; wb_valid = 1'b1; wb_addr = 5'd8; wb_data = 64'h88;
    instr(1'b1, 5'd7, 64'h77, 1'b1, 5'd8, 64'h8080, 1'b1, 5'd10, 1'b0);
    @(posedge clk); #1;
    total++; if ({sb.ex_op1, sb.ex_op2} !== {64'hC, 64'h88}) begin bad++; $display("FAIL fwd_stage2_wb: got %h %h want c 88", sb.ex_op1, sb.ex_op2); end
    @(negedge clk); idle(); instr(1'b1, 5'd7, 64'h77, 1'b1, 5'd8, 64'h8080, 1'b0, 5'd0, 1'b0);
    @(posedge clk); #1;
    total++; if ({sb.ex_op1, sb.ex_op2} !== {64'h77, 64'h8080}) begin bad++; $display("FAIL fwd_regfile: got %h %h want 77 8080", sb.ex_op1, sb.ex_op2); end
    total++; if (pend_cnt !== 3'd0) begin bad++; $display("FAIL fwd_wb_ignored: pend_cnt=%0d want 0", pend_cnt); end
    @(negedge clk); idle();
  endtask

  task automatic test_capacity();
    int drain[4] = '{1, 3, 4, 6};
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); idle(); instr(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'(i), 1'b1); #1;
      total++; if (sb.id_ready !== 1'b1) begin bad++; $display("FAIL cap_fill: x%0d id_ready=%0b want 1", i, sb.id_ready); end
      @(posedge clk);
    end
    #1;
    total++; if (pend_cnt !== 3'd4) begin bad++; $display("FAIL cap_full: pend_cnt=%0d want 4", pend_cnt); end
    @(negedge clk); idle(); instr(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd6, 1'b1); #1;
    total++; if (sb.id_ready !== 1'b0) begin bad++; $display("FAIL cap_stall: id_ready=%0b want 0", sb.id_ready); end
    @(negedge clk); wb_valid = 1'b1; wb_addr = 5'd2; wb_data = 64'h2; #1;
    total++; if (sb.id_ready !== 1'b1) begin bad++; $display("FAIL cap_wb_release: id_ready=%0b want 1", sb.id_ready); end
    @(posedge clk); #1;
    total++; if (pend_cnt !== 3'd4) begin bad++; $display("FAIL cap_net_zero: pend_cnt=%0d want 4", pend_cnt); end
    total++; if ({sb.ex_valid, sb.ex_rd_addr} !== {1'b1, 5'd6}) begin bad++; $display("FAIL cap_ex_rd: got %b want 1_00110", {sb.ex_valid, sb.ex_rd_addr}); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); idle(); wb_valid = 1'b1; wb_addr = 5'(drain[k]);
      @(posedge clk);
    end
    #1;
    total++; if (pend_cnt !== 3'd0) begin bad++; $display("FAIL cap_drain: pend_cnt=%0d want 0", pend_cnt); end
  endtask

  task automatic test_flush();
    @(negedge clk); idle(); sb.ex_ready = 1'b0;
    instr(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 1'b1);
    @(posedge clk); #1;
    total++; if ({sb.ex_valid, pend_cnt} !== {1'b1, 3'd1}) begin bad++; $display("FAIL flush_setup: got %b want 1_001", {sb.ex_valid, pend_cnt}); end
    @(negedge clk); idle(); flush = 1'b1;
    instr(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd10, 1'b0); #1;
    total++; if (sb.id_ready !== 1'b0) begin bad++; $display("FAIL flush_blocks_issue: id_ready=%0b want 0", sb.id_ready); end
    @(posedge clk); #1;
    total++; if ({sb.ex_valid, pend_cnt} !== {1'b0, 3'd0}) begin bad++; $display("FAIL flush_kill: got %b want 0_000", {sb.ex_valid, pend_cnt}); end
    @(negedge clk); idle(); instr(1'b1, 5'd9, 64'h99, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0); #1;
    total++; if (sb.id_ready !== 1'b1) begin bad++; $display("FAIL flush_pend9_clear: id_ready=%0b want 1", sb.id_ready); end
    @(posedge clk); #1;
    @(negedge clk); idle();
  endtask

  task automatic test_back_to_back();
    @(negedge clk); idle(); instr(1'b1, 5'd3, 64'h33, 1'b0, 5'd0, 64'd0, 1'b1, 5'd11, 1'b0);
    @(posedge clk); #1;
    total++; if (sb.ex_op1 !== 64'h33) begin bad++; $display("FAIL b2b_first: ex_op1=%h want 33", sb.ex_op1); end
    @(negedge clk); idle(); sb.ex_ready = 1'b0;
    instr(1'b1, 5'd4, 64'h44, 1'b0, 5'd0, 64'd0, 1'b1, 5'd12, 1'b0); #1;
    total++; if (sb.id_ready !== 1'b0) begin bad++; $display("FAIL b2b_backpressure: id_ready=%0b want 1'b0", sb.id_ready); end
    @(posedge clk); #1;
    total++; if ({sb.ex_valid, sb.ex_op1, sb.ex_rd_addr} !== {1'b1, 64'h33, 5'd11}) begin bad++; $display("FAIL b2b_hold: got %0b %h %0d want 1 33 11", sb.ex_valid, sb.ex_op1, sb.ex_rd_addr); end
    @(negedge clk); sb.ex_ready = 1'b1; #1;
    total++; if (sb.id_ready !== 1'b1) begin bad++; $display("FAIL b2b_resume: id_ready=%0b want 1", sb.id_ready); end
    @(posedge clk); #1;
    total++; if ({sb.ex_op1, sb.ex_rd_addr} !== {64'h44, 5'd12}) begin bad++; $display("FAIL b2b_second: got %h %0d want 44 12", sb.ex_op1, sb.ex_rd_addr); end
    @(negedge clk); idle();
    @(posedge clk); #1;
    total++; if (sb.ex_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain: ex_valid=%0b want 0", sb.ex_valid); end
  endtask

  task automatic test_x0_and_reset();
    @(negedge clk); idle();
    fwd_vld = 3'b001; fwd_addr = 15'd0; fwd_data = {128'd0, 64'hFF};
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 64'hEE;
    instr(1'b1, 5'd0, 64'h123, 1'b1, 5'd0, 64'h456, 1'b0, 5'd0, 1'b0);
    @(posedge clk); #1;
    total++; if ({sb.ex_valid, sb.ex_op1, sb.ex_op2} !== {1'b1, 128'd0}) begin bad++; $display("FAIL x0_zero: got %0b %h %h want 1 0 0", sb.ex_valid, sb.ex_op1, sb.ex_op2); end
    @(negedge clk); idle(); instr(1'b1, 5'd13, 64'hDEAD, 1'b0, 5'd0, 64'd0, 1'b1, 5'd12, 1'b1);
    @(posedge clk); #1;
    total++; if ({sb.ex_valid, sb.ex_op1, pend_cnt} !== {1'b1, 64'hDEAD, 3'd1}) begin bad++; $display("FAIL async_setup: got %0b %h %0d", sb.ex_valid, sb.ex_op1, pend_cnt); end
    @(negedge clk); idle(); sb.ex_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    total++; if ({sb.ex_valid, sb.ex_op1, sb.ex_op2, sb.ex_rd_ena, sb.ex_rd_addr, sb.ex_rd_long, pend_cnt} !== 138'd0) begin bad++; $display("FAIL async_reset: outputs not cleared, ex_valid=%0b op1=%h pend_cnt=%0d", sb.ex_valid, sb.ex_op1, pend_cnt); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); idle(); wb_valid = 1'b1; wb_addr = 5'd12;
    instr(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd14, 1'b1);
    @(posedge clk); #1;
    total++; if (pend_cnt !== 3'd1) begin bad++; $display("FAIL stale_wb_ignored: pend_cnt=%0d want 1", pend_cnt); end
  endtask

  task automatic test_random();
    int          pq[$];
    int          roll;
    bit          haz, exp_ready;
    bit [31:0]   nxt;
    logic [63:0] e1, e2;
    do_reset();
    pend_m = 32'd0; ex_v_m = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      sb.id_valid = ($urandom_range(0, 99) < 80);
      sb.rs1_ena = ($urandom_range(0, 99) < 80); sb.rs1_addr = 5'($urandom_range(0, 7));
      sb.rs2_ena = ($urandom_range(0, 99) < 80); sb.rs2_addr = 5'($urandom_range(0, 7));
      sb.rs1_data = {$urandom, $urandom}; sb.rs2_data = {$urandom, $urandom};
      sb.rd_ena = ($urandom_range(0, 99) < 70); sb.rd_addr = 5'($urandom_range(0, 7));
      sb.rd_long = ($urandom_range(0, 99) < 40);
      sb.ex_ready = ($urandom_range(0, 99) < 75);
      flush = ($urandom_range(0, 99) < 5);
      fwd_vld = 3'($urandom_range(0, 7));
      fwd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      fwd_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pq = {};
      for (int r = 1; r < 32; r++) if (pend_m[r]) pq.push_back(r);
      roll = $urandom_range(0, 99);
      wb_valid = 1'b0; wb_addr = 5'd0; wb_data = {$urandom, $urandom};
      if (roll < 40 && pq.size() > 0) begin
        wb_valid = 1'b1; wb_addr = 5'(pq[$urandom_range(0, pq.size() - 1)]);
      end else if (roll < 50 && pq.size() < MAXL) begin
        wb_valid = 1'b1; wb_addr = 5'($urandom_range(0, 7));
      end
      haz = (sb.rs1_ena && sb.rs1_addr != 0 && pend_m[sb.rs1_addr] && !(wb_valid && wb_addr == sb.rs1_addr))
         || (sb.rs2_ena && sb.rs2_addr != 0 && pend_m[sb.rs2_addr] && !(wb_valid && wb_addr == sb.rs2_addr))
         || (sb.rd_ena && sb.rd_addr != 0 && pend_m[sb.rd_addr] && !(wb_valid && wb_addr == sb.rd_addr))
         || (sb.rd_long && sb.rd_ena && sb.rd_addr != 0 && $countones(pend_m) == MAXL && !wb_valid);
      exp_ready = sb.id_valid && !flush && !haz && (!ex_v_m || sb.ex_ready);
      e1 = m_operand(sb.rs1_ena, sb.rs1_addr, sb.rs1_data);
      e2 = m_operand(sb.rs2_ena, sb.rs2_addr, sb.rs2_data);
      #1;
      total++; if (sb.id_ready !== exp_ready) begin bad++; $display("FAIL rand_id_ready: cycle %0d got %0b want %0b", n, sb.id_ready, exp_ready); end
      nxt = pend_m;
      if (wb_valid && pend_m[wb_addr]) nxt[wb_addr] = 1'b0;
      if (flush && ex_v_m && rdl_m && rde_m && pend_m[rda_m]) nxt[rda_m] = 1'b0;
      if (exp_ready && sb.rd_long && sb.rd_ena && sb.rd_addr != 0) nxt[sb.rd_addr] = 1'b1;
      if (flush) ex_v_m = 1'b0;
      else if (exp_ready) begin
        ex_v_m = 1'b1; op1_m = e1; op2_m = e2;
        rde_m = sb.rd_ena; rda_m = sb.rd_addr; rdl_m = sb.rd_long;
      end else if (sb.ex_ready) ex_v_m = 1'b0;
      pend_m = nxt;
      @(posedge clk); #1;
      total++; if (sb.ex_valid !== ex_v_m) begin bad++; $display("FAIL rand_ex_valid: cycle %0d got %0b want %0b", n, sb.ex_valid, ex_v_m); end
      if (ex_v_m) begin
        total++; if ({sb.ex_op1, sb.ex_op2} !== {op1_m, op2_m}) begin bad++; $display("FAIL rand_ops: cycle %0d got %h %h want %h %h", n, sb.ex_op1, sb.ex_op2, op1_m, op2_m); end
        total++; if ({sb.ex_rd_ena, sb.ex_rd_addr, sb.ex_rd_long} !== {rde_m, rda_m, rdl_m}) begin bad++; $display("FAIL rand_rd: cycle %0d got %b want %b", n, {sb.ex_rd_ena, sb.ex_rd_addr, sb.ex_rd_long}, {rde_m, rda_m, rdl_m}); end
      end
      total++; if (pend_cnt !== 3'($countones(pend_m))) begin bad++; $display("FAIL rand_pend_cnt: cycle %0d got %0d want %0d", n, pend_cnt, $countones(pend_m)); end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_load_use();
    test_fwd_priority();
    test_capacity();
    test_flush();
    test_back_to_back();
    test_x0_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
